// File: rtl/gray_ptr_sync_decode.sv
// rtl/gray_ptr_sync_decode.sv - gray pointer synchronizer, decoder and step monitor (optional checker: GRAY_STEP_CHECK_EN)
module gray_ptr_sync_decode #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_sync,
    output logic             upd,
    output logic             inc,
    output logic             wrap,
    output logic             step_err,
    output logic [CNT_W-1:0] upd_cnt
);

    // Synchronizer chain; the last stage is exported as gray_sync.
    logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
    // Tracks how far real post-reset samples have travelled down the chain.
    logic [SYNC_STAGES-1:0] fill_q;
    // High until the first real sample has been decoded after reset.
    logic                   prime;

    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] bin_plus_one;
    logic             changed;
    logic             is_inc;
    logic             is_wrap;
    logic             sync_valid;

    assign gray_sync  = sync_q[SYNC_STAGES-1];
    assign sync_valid = fill_q[SYNC_STAGES-1];

    // Plain flop chain, no logic between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Fill marker shifts alongside the data so the first real sample is known.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
        end else begin
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        bin_next = '0;
        bin_next[WIDTH-1] = gray_sync[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin_next[i] = bin_next[i+1] ^ gray_sync[i];
        end
    end

    // Classify the pending transition against the current output.
    always_comb begin
        bin_plus_one = bin_out + 1'b1;
        changed      = (bin_next != bin_out);
        is_inc       = (bin_next == bin_plus_one);
        is_wrap      = (&bin_out) && (bin_next == '0);
    end

    // Output register, event pulses, prime handling and saturating counter.
    // The prime sample is the first decode of real data after reset; it may
    // or may not differ from zero, and it is never reported as a step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_out <= '0;
            upd     <= 1'b0;
            inc     <= 1'b0;
            wrap    <= 1'b0;
            upd_cnt <= '0;
            prime   <= 1'b1;
        end else begin
            upd  <= 1'b0;
            inc  <= 1'b0;
            wrap <= 1'b0;
            if (sync_valid) begin
                bin_out <= bin_next;
                prime   <= 1'b0;
                if (changed) begin
                    upd  <= 1'b1;
                    inc  <= is_inc && !prime;
                    wrap <= is_wrap && !prime;
                    if (upd_cnt != {CNT_W{1'b1}}) begin
                        upd_cnt <= upd_cnt + 1'b1;
                    end
                end
            end
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    // Gray word that corresponds to the value currently held in bin_out.
    logic [WIDTH-1:0] gray_prev;
    logic [WIDTH-1:0] gray_diff;
    logic [$clog2(WIDTH+1)-1:0] diff_pop;
    logic             multi_step;

    assign gray_prev = bin_out ^ (bin_out >> 1);
    assign gray_diff = gray_sync ^ gray_prev;

    // Number of gray bits that flip in the pending transition.
    always_comb begin
        diff_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            diff_pop = diff_pop + {{($clog2(WIDTH+1)-1){1'b0}}, gray_diff[i]};
        end
        multi_step = (diff_pop > 1);
    end

    // Sticky error; a fresh error outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_err <= 1'b0;
        end else if (sync_valid && changed && !prime && multi_step) begin
            step_err <= 1'b1;
        end else if (err_clr) begin
            step_err <= 1'b0;
        end
    end
`else
    logic err_clr_unused;

    assign err_clr_unused = err_clr;
    assign step_err       = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync_decode.sv
// tb/tb_gray_ptr_sync_decode.sv - scoreboard bench for gray_ptr_sync_decode
module tb_gray_ptr_sync_decode;

    logic       clk;
    logic       rst_n;
    logic [3:0] gray_in;
    logic       err_clr;
    logic [3:0] bin_out;
    logic [3:0] gray_sync;
    logic       upd;
    logic       inc;
    logic       wrap;
    logic       step_err;
    logic [7:0] upd_cnt;

`ifdef GRAY_STEP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct {
        logic [3:0] bin;
        logic       inc;
        logic       wrap;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cnt_model;
    int   total;
    int   bad;

    gray_ptr_sync_decode #(.WIDTH(4), .SYNC_STAGES(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gray_in   (gray_in),
        .err_clr   (err_clr),
        .bin_out   (bin_out),
        .gray_sync (gray_sync),
        .upd       (upd),
        .inc       (inc),
        .wrap      (wrap),
        .step_err  (step_err),
        .upd_cnt   (upd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: every upd pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (upd) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_upd: got bin_out=%0d with no pending expectation", bin_out);
                end else begin
                    e = q.pop_front();
                    total++;
                    if (bin_out !== e.bin) begin
                        bad++;
                        $display("FAIL upd_bin: got %0d want %0d", bin_out, e.bin);
                    end
                    total++;
                    if (inc !== e.inc) begin
                        bad++;
                        $display("FAIL upd_inc: got %0b want %0b (bin %0d)", inc, e.inc, e.bin);
                    end
                    total++;
                    if (wrap !== e.wrap) begin
                        bad++;
                        $display("FAIL upd_wrap: got %0b want %0b (bin %0d)", wrap, e.wrap, e.bin);
                    end
                    total++;
                    if (upd_cnt !== e.cnt) begin
                        bad++;
                        $display("FAIL upd_cnt: got %0d want %0d", upd_cnt, e.cnt);
                    end
                end
            end else if (inc || wrap) begin
                total++;
                bad++;
                $display("FAIL stray_pulse: got inc=%0b wrap=%0b want 0 without upd", inc, wrap);
            end
        end
    end

    task automatic push_exp(input logic [3:0] b, input logic i, input logic w);
        if (cnt_model < 255) cnt_model++;
        q.push_back('{b, i, w, cnt_model[7:0]});
    endtask

    task automatic drive_bin(input logic [3:0] b, input logic i, input logic w);
        @(posedge clk);
        #1;
        gray_in = b ^ (b >> 1);
        push_exp(b, i, w);
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 60 && q.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d pending want 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic do_reset(input logic [3:0] g);
        rst_n     = 1'b0;
        gray_in   = g;
        q.delete();
        cnt_model = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        err_clr = 1'b0;
        rst_n   = 1'b0;
        gray_in = 4'b0000;
        q.delete();
        cnt_model = 0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bin_out, gray_sync, upd, inc, wrap, step_err, upd_cnt} !== 24'h0) begin
            bad++;
            $display("FAIL reset_state: got bin=%0d gs=%0d upd=%0b inc=%0b wrap=%0b err=%0b cnt=%0d want all 0",
                     bin_out, gray_sync, upd, inc, wrap, step_err, upd_cnt);
        end
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (upd_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_idle_cnt: got %0d want 0", upd_cnt);
        end
    endtask

    task automatic test_count();
        @(posedge clk);
        #1;
        gray_in = 4'b0001;
        push_exp(4'd1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bin_out !== 4'd0) begin
            bad++;
            $display("FAIL latency_early: got %0d want 0", bin_out);
        end
        @(posedge clk);
        #1;
        total++;
        if (bin_out !== 4'd1) begin
            bad++;
            $display("FAIL latency_due: got %0d want 1", bin_out);
        end
        repeat (3) @(posedge clk);
        drive_bin(4'd2, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        drive_bin(4'd3, 1'b1, 1'b0);
        wait_drain("count");
        total++;
        if (upd_cnt !== 8'd3 || step_err !== 1'b0) begin
            bad++;
            $display("FAIL count_final: got cnt=%0d err=%0b want cnt=3 err=0", upd_cnt, step_err);
        end
    endtask

    task automatic test_wrap();
        for (int b = 4; b < 16; b++) drive_bin(b[3:0], 1'b1, 1'b0);
        drive_bin(4'd0, 1'b1, 1'b1);
        wait_drain("wrap");
        total++;
        if (bin_out !== 4'd0 || step_err !== 1'b0 || upd_cnt !== 8'd16) begin
            bad++;
            $display("FAIL wrap_final: got bin=%0d err=%0b cnt=%0d want bin=0 err=0 cnt=16", bin_out, step_err, upd_cnt);
        end
    endtask

    task automatic test_jump();
        drive_bin(4'd1, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        drive_bin(4'd5, 1'b0, 1'b0);
        wait_drain("jump");
        total++;
        if (bin_out !== 4'd5 || step_err !== EXP_ERR) begin
            bad++;
            $display("FAIL jump_err: got bin=%0d err=%0b want bin=5 err=%0b", bin_out, step_err, EXP_ERR);
        end
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (step_err !== EXP_ERR) begin
            bad++;
            $display("FAIL jump_sticky: got %0b want %0b", step_err, EXP_ERR);
        end
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        total++;
        if (step_err !== 1'b0) begin
            bad++;
            $display("FAIL err_clr: got %0b want 0", step_err);
        end
    endtask

    task automatic test_prime_hold();
        do_reset(4'b0110);
        push_exp(4'd4, 1'b0, 1'b0);
        wait_drain("prime");
        total++;
        if (bin_out !== 4'd4 || step_err !== 1'b0) begin
            bad++;
            $display("FAIL prime_exempt: got bin=%0d err=%0b want bin=4 err=0", bin_out, step_err);
        end
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (upd_cnt !== 8'd1) begin
            bad++;
            $display("FAIL prime_silence: got cnt=%0d want 1", upd_cnt);
        end
    endtask

    task automatic test_mid_reset();
        drive_bin(4'd5, 1'b1, 1'b0);
        drive_bin(4'd6, 1'b1, 1'b0);
        drive_bin(4'd7, 1'b1, 1'b0);
        wait_drain("pre_reset");
        total++;
        if (bin_out !== 4'd7 || upd_cnt !== 8'd4) begin
            bad++;
            $display("FAIL pre_reset: got bin=%0d cnt=%0d want bin=7 cnt=4", bin_out, upd_cnt);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        cnt_model = 0;
        #1;
        total++;
        if (bin_out !== 4'd0 || upd_cnt !== 8'd0 || gray_sync !== 4'd0) begin
            bad++;
            $display("FAIL async_reset: got bin=%0d cnt=%0d gs=%0d want 0 0 0", bin_out, upd_cnt, gray_sync);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(4'd7, 1'b0, 1'b0);
        wait_drain("refill");
        drive_bin(4'd8, 1'b1, 1'b0);
        wait_drain("post_refill");
        total++;
        if (bin_out !== 4'd8 || upd_cnt !== 8'd2) begin
            bad++;
            $display("FAIL refill: got bin=%0d cnt=%0d want bin=8 cnt=2", bin_out, upd_cnt);
        end
    endtask

    task automatic test_saturate();
        do_reset(4'b0000);
        repeat (6) @(posedge clk);
        for (int i = 1; i <= 300; i++) begin
            drive_bin(i[3:0], 1'b1, (i % 16) == 0);
        end
        wait_drain("saturate");
        total++;
        if (upd_cnt !== 8'd255 || bin_out !== 4'd12) begin
            bad++;
            $display("FAIL saturate: got cnt=%0d bin=%0d want cnt=255 bin=12", upd_cnt, bin_out);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        cnt_model = 0;
        gray_in   = 4'b0000;
        err_clr   = 1'b0;
        rst_n     = 1'b0;
        test_reset();
        test_count();
        test_wrap();
        test_jump();
        test_prime_hold();
        test_mid_reset();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
